// File: rtl/ppl_fb_writer.sv
// rtl/ppl_fb_writer.sv - ray-pipeline pixel sink: FIFO, texture fetch, skid, RGB565 frame-buffer writes
// Optional sky bypass for no-hit texels: define PPL_SKY_BYPASS_EN.
module ppl_fb_writer #(
    parameter int          H_DISP     = 1280,
    parameter int          V_DISP     = 720,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] SKY_COLOR  = 16'h867D
) (
    input  logic        clk_ppl,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [19:0] pixel_addr_in,
    input  logic [12:0] texture_addr_in,
    output logic        in_almost_full,
    output logic        overflow,
    output logic        tex_rd_en,
    output logic [12:0] tex_rd_addr,
    input  logic [15:0] tex_rd_data,
    output logic        fb_wr_valid,
    input  logic        fb_wr_ready,
    output logic [19:0] fb_wr_addr,
    output logic [15:0] fb_wr_data,
    output logic        frame_done
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [19:0] LAST_ADDR = 20'(H_DISP * V_DISP - 1);

    logic [32:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [19:0] head_pix;
    logic [12:0] head_tex;
    logic        head_sky;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        out_blocked;

    logic        s1_valid;
    logic [19:0] s1_addr;
    logic        s1_sky;
    logic [15:0] s1_data;
    logic        s1_to_skid;

    logic        sk_valid;
    logic [19:0] sk_addr;
    logic [15:0] sk_data;

    assign head_pix   = mem[rd_ptr][32:13];
    assign head_tex   = mem[rd_ptr][12:0];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));

`ifdef PPL_SKY_BYPASS_EN
    assign head_sky = (head_tex == 13'd0);
`else
    assign head_sky = 1'b0;
`endif

    assign out_blocked = fb_wr_valid && !fb_wr_ready;
    // Popping only when the skid is free guarantees the word read now always has a home.
    assign pop         = !fifo_empty && !sk_valid && !(s1_valid && out_blocked);
    assign push        = in_valid && (!fifo_full || pop);

    assign tex_rd_en   = pop && !head_sky;
    assign tex_rd_addr = tex_rd_en ? head_tex : 13'd0;

    assign s1_data     = s1_sky ? SKY_COLOR : tex_rd_data;
    assign s1_to_skid  = s1_valid && (out_blocked || sk_valid);

    assign in_almost_full = (count >= CW'(FIFO_DEPTH - 2));

    always_ff @(posedge clk_ppl) begin
        if (push) begin
            mem[wr_ptr] <= {pixel_addr_in, texture_addr_in};
        end
    end

    always_ff @(posedge clk_ppl or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (in_valid && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_ppl or negedge rst) begin
        if (!rst) begin
            s1_valid    <= 1'b0;
            s1_addr     <= '0;
            s1_sky      <= 1'b0;
            sk_valid    <= 1'b0;
            sk_addr     <= '0;
            sk_data     <= '0;
            fb_wr_valid <= 1'b0;
            fb_wr_addr  <= '0;
            fb_wr_data  <= '0;
            frame_done  <= 1'b0;
        end else begin
            s1_valid <= pop;
            if (pop) begin
                s1_addr <= head_pix;
                s1_sky  <= head_sky;
            end

            // Skid has priority so arrival order is preserved.
            if (!out_blocked) begin
                if (sk_valid) begin
                    fb_wr_valid <= 1'b1;
                    fb_wr_addr  <= sk_addr;
                    fb_wr_data  <= sk_data;
                end else if (s1_valid) begin
                    fb_wr_valid <= 1'b1;
                    fb_wr_addr  <= s1_addr;
                    fb_wr_data  <= s1_data;
                end else begin
                    fb_wr_valid <= 1'b0;
                end
            end

            if (s1_to_skid) begin
                sk_valid <= 1'b1;
                sk_addr  <= s1_addr;
                sk_data  <= s1_data;
            end else if (!out_blocked && sk_valid) begin
                sk_valid <= 1'b0;
            end

            frame_done <= fb_wr_valid && fb_wr_ready && (fb_wr_addr == LAST_ADDR);
        end
    end

endmodule
